decimal_entry_reader: RTL and testbench



---
 rtl/decimal_entry_reader.sv | 112 +++++++++++
 tb/tb_decimal_entry_reader.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/decimal_entry_reader.sv
// decimal_entry_reader: debounced switch/key decimal digit entry; optional DECIMAL_ENTRY_BCD_OUT_EN adds entry_bcd
module decimal_entry_reader #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_DIGITS = 3
) (
  input  logic       MAX10_CLK1_50,
  input  logic       RESET_N,
  input  logic       KEY_N,
  input  logic [3:0] digit_in,
  input  logic       commit_in,
  output logic [9:0] entry,
  output logic [1:0] digits,
  output logic [9:0] value,
  output logic       value_valid,
  output logic       err,
  output logic       busy
`ifdef DECIMAL_ENTRY_BCD_OUT_EN
  , output logic [4*MAX_DIGITS-1:0] entry_bcd
`endif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [1:0] ENTRY = 2'd0, UPDATE = 2'd1, COMMIT = 2'd2;
  logic key_s1, key_s2, commit_s1, commit_s2, db, db_d, press;
  logic [3:0] digit_s1, digit_s2, dig_l;
  logic [CW-1:0] cnt;
  logic [1:0] state;
  assign busy = state != ENTRY;
  // two-flop synchronizers; key idles released
  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N)
    if (!RESET_N) begin
      {key_s1, key_s2} <= 2'b11;
      {commit_s1, commit_s2} <= 2'b00;
      digit_s1 <= '0;
      digit_s2 <= '0;
    end else begin
      {key_s1, key_s2} <= {KEY_N, key_s1};
      {commit_s1, commit_s2} <= {commit_in, commit_s1};
      digit_s1 <= digit_in;
      digit_s2 <= digit_s1;
    end
  // debouncer: accept a level only after it differs for DEBOUNCE_CYCLES cycles
  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N)
    if (!RESET_N) begin
      cnt <= '0;
      db <= 1'b1;
    end else if (key_s2 == db) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt <= '0;
      db <= key_s2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  // press pulse on each debounced fall; releases are ignored
  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N)
    if (!RESET_N) begin
      db_d <= 1'b1;
      press <= 1'b0;
    end else begin
      db_d <= db;
      press <= db_d & ~db;
    end
  // entry FSM: validate presses, accumulate digits, publish on commit
  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N)
    if (!RESET_N) begin
      state <= ENTRY;
      entry <= '0;
      digits <= '0;
      value <= '0;
      value_valid <= 1'b0;
      err <= 1'b0;
      dig_l <= '0;
`ifdef DECIMAL_ENTRY_BCD_OUT_EN
      entry_bcd <= '0;
`endif
    end else begin
      value_valid <= 1'b0;
      if (state == ENTRY) begin
        if (press) begin
          if (commit_s2) begin
            if (digits != 2'd0) begin
              value <= entry;
              value_valid <= 1'b1;
              state <= COMMIT;
            end else begin
              err <= 1'b1;
            end
          end else if (digit_s2 > 4'd9 || digits == 2'(MAX_DIGITS)) begin
            err <= 1'b1;
          end else begin
            dig_l <= digit_s2;
            state <= UPDATE;
          end
        end
      end else if (state == UPDATE) begin
        entry <= (entry << 3) + (entry << 1) + {6'd0, dig_l};
        digits <= digits + 2'd1;
`ifdef DECIMAL_ENTRY_BCD_OUT_EN
        entry_bcd <= {entry_bcd[4*MAX_DIGITS-5:0], dig_l};
`endif
        state <= ENTRY;
      end else begin
        entry <= '0;
        digits <= '0;
        err <= 1'b0;
`ifdef DECIMAL_ENTRY_BCD_OUT_EN
        entry_bcd <= '0;
`endif
        state <= ENTRY;
      end
    end
endmodule

// File: tb/tb_decimal_entry_reader.sv
// tb_decimal_entry_reader: randomized and directed checks against a digit-entry reference model
module tb_decimal_entry_reader;
  localparam int D = 4;
  localparam int MD = 3;
  logic clk = 1'b0, rst_n = 1'b0, key_n = 1'b1, commit = 1'b0;
  logic [3:0] digit = '0;
  logic [9:0] entry, value;
  logic [1:0] digits;
  logic value_valid, err, busy;
`ifdef DECIMAL_ENTRY_BCD_OUT_EN
  logic [4*MD-1:0] entry_bcd;
  int m_bcd;
`endif
  int errors = 0, checks = 0;
  int m_entry = 0, m_digits = 0, m_value = 0, m_err = 0, m_vv = 0, m_busy = 0;
  int vv_cnt = 0, busy_cnt = 0;
  always #5 clk = ~clk;
  decimal_entry_reader #(.DEBOUNCE_CYCLES(D), .MAX_DIGITS(MD)) dut (
    .MAX10_CLK1_50(clk), .RESET_N(rst_n), .KEY_N(key_n), .digit_in(digit), .commit_in(commit),
    .entry(entry), .digits(digits), .value(value), .value_valid(value_valid), .err(err), .busy(busy)
`ifdef DECIMAL_ENTRY_BCD_OUT_EN
    , .entry_bcd(entry_bcd)
`endif
  );
  always @(negedge clk) begin
    if (value_valid) vv_cnt++;
    if (busy) busy_cnt++;
  end
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_entry = 0; m_digits = 0; m_value = 0; m_err = 0;
`ifdef DECIMAL_ENTRY_BCD_OUT_EN
    m_bcd = 0;
`endif
  endtask
  task automatic model_press(input int d, input bit c);
    if (c) begin
      if (m_digits > 0) begin
        m_value = m_entry; m_entry = 0; m_digits = 0; m_err = 0; m_vv++; m_busy++;
`ifdef DECIMAL_ENTRY_BCD_OUT_EN
        m_bcd = 0;
`endif
      end else m_err = 1;
    end else if (d > 9 || m_digits == MD) m_err = 1;
    else begin
      m_entry = m_entry * 10 + d; m_digits++; m_busy++;
`ifdef DECIMAL_ENTRY_BCD_OUT_EN
      m_bcd = m_bcd * 16 + d;
`endif
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".entry"}, entry, m_entry);
    chk({tag, ".digits"}, digits, m_digits);
    chk({tag, ".value"}, value, m_value);
    chk({tag, ".err"}, err, m_err);
    chk({tag, ".vv"}, vv_cnt, m_vv);
    chk({tag, ".busy"}, busy_cnt, m_busy);
`ifdef DECIMAL_ENTRY_BCD_OUT_EN
    chk({tag, ".bcd"}, entry_bcd, m_bcd);
`endif
  endtask
  task automatic press(input int d, input bit c);
    @(negedge clk);
    digit = 4'(d); commit = c; key_n = 1'b0;
    repeat (D + 8) @(negedge clk);
    key_n = 1'b1;
    repeat (D + 8) @(negedge clk);
    model_press(d, c);
  endtask
  initial begin
    int k;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check_all("reset");
    chk("reset.busy_now", busy, 0);
    // latency from first sampling edge to entry update is sync + debounce + press + 2
    @(negedge clk);
    digit = 4'd1; commit = 1'b0; key_n = 1'b0;
    for (k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      if (entry != 10'd0) break;
    end
    chk("latency", k, D + 5);
    repeat (D + 6) @(negedge clk);
    key_n = 1'b1;
    repeat (D + 8) @(negedge clk);
    model_press(1, 0);
    check_all("d1");
    press(2, 0); check_all("d12");
    press(3, 0); check_all("d123");
    press(0, 1); check_all("commit123");
    chk("value123", value, 123);
    // bounces shorter than the debounce window
    @(negedge clk);
    digit = 4'd7; key_n = 1'b0;
    repeat (2) @(negedge clk); key_n = 1'b1;
    @(negedge clk); key_n = 1'b0;
    repeat (2) @(negedge clk); key_n = 1'b1;
    repeat (D + 8) @(negedge clk);
    check_all("bounce");
    press(7, 0); check_all("after_bounce");
    chk("entry7", entry, 7);
    press(0, 1); check_all("commit7");
    press(12, 0); check_all("bad_digit");
    chk("err_bad", err, 1);
    press(9, 0); press(9, 0); press(9, 0); press(4, 0); check_all("overflow");
    chk("entry999", entry, 999);
    press(0, 1); check_all("commit999");
    chk("err_clear", err, 0);
    press(0, 1); check_all("empty_commit");
    chk("err_empty", err, 1);
    press(4, 0); press(0, 0); press(9, 0); check_all("d409");
    press(0, 1); check_all("commit409");
    // reset during UPDATE discards the digit
    @(negedge clk);
    digit = 4'd5; commit = 1'b0; key_n = 1'b0;
    for (k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (busy) break;
    end
    chk("busy_seen", busy, 1);
    rst_n = 1'b0; key_n = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (D + 8) @(negedge clk);
    check_all("mid_reset");
    for (int i = 0; i < 40; i++) begin
      bit c;
      int d;
      c = ($urandom_range(0, 3) == 0);
      d = $urandom_range(0, 12);
      press(d, c);
      check_all($sformatf("rnd%0d", i));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
